// File: rtl/spart_bus_ctrl_if.sv
// CPU-side I/O bus of the mini SPART: chip select, direction, register address, data in/out and the two status flags.
interface spart_bus_ctrl_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_in;
  logic [7:0] databus_out;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs, iorw, ioaddr, databus_in,
    input  databus_out, rda, tbr
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus_in,
    output databus_out, rda, tbr
  );
endinterface

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: CPU register interface, 16x baud tick generator and rx/tx sequencing for the mini SPART.
// Define SPART_RX_FIFO_EN to replace the single rx holding register with an RX_FIFO_DEPTH-entry FIFO.
module spart_bus_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'd162
`ifdef SPART_RX_FIFO_EN
  , parameter int RX_FIFO_DEPTH = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  spart_bus_ctrl_if.slave  bus,
  output logic             baud,
  input  logic             rx_rda,
  input  logic [7:0]       rx_data,
  input  logic             tx_tbr,
  output logic             tx_start,
  output logic [7:0]       tx_data
);
  logic rd_access, wr_access;
  logic data_rd, stat_rd, data_wr, lo_wr, hi_wr;

  assign rd_access = bus.iocs & bus.iorw;
  assign wr_access = bus.iocs & ~bus.iorw;
  assign data_rd   = rd_access & (bus.ioaddr == 2'b00);
  assign stat_rd   = rd_access & (bus.ioaddr == 2'b01);
  assign data_wr   = wr_access & (bus.ioaddr == 2'b00);
  assign lo_wr     = wr_access & (bus.ioaddr == 2'b10);
  assign hi_wr     = wr_access & (bus.ioaddr == 2'b11);

  logic [15:0] div_reg;
  logic [7:0]  stage_reg;
  logic [15:0] cnt_reg;
  logic        baud_reg;

  // A high-byte write commits the divisor and restarts the count, suppressing any tick that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg   <= DIV_RESET;
      stage_reg <= DIV_RESET[7:0];
      cnt_reg   <= DIV_RESET;
      baud_reg  <= 1'b0;
    end else begin
      if (lo_wr)
        stage_reg <= bus.databus_in;
      if (hi_wr) begin
        div_reg  <= {bus.databus_in, stage_reg};
        cnt_reg  <= {bus.databus_in, stage_reg};
        baud_reg <= 1'b0;
      end else if (cnt_reg == 16'd0) begin
        cnt_reg  <= div_reg;
        baud_reg <= 1'b1;
      end else begin
        cnt_reg  <= cnt_reg - 16'd1;
        baud_reg <= 1'b0;
      end
    end
  end

  logic rx_prev_reg;
  logic push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rx_prev_reg <= 1'b1;
    else
      rx_prev_reg <= rx_rda;
  end

  assign push = rx_rda & ~rx_prev_reg;

  logic       empty, full, pop, wr_en, ovr_event;
  logic [7:0] head;

`ifdef SPART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(RX_FIFO_DEPTH);

  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  assign head      = mem[rd_ptr_reg];
  assign pop       = data_rd & ~empty;
  assign wr_en     = push & (~full | pop);
  assign ovr_event = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
`else
  logic [7:0] hold_reg;
  logic       full_reg;

  assign empty     = ~full_reg;
  assign full      = full_reg;
  assign head      = hold_reg;
  assign pop       = data_rd & full;
  assign wr_en     = push & (~full | pop);
  assign ovr_event = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= 8'h00;
      full_reg <= 1'b0;
    end else begin
      if (wr_en)
        hold_reg <= rx_data;
      full_reg <= wr_en | (full_reg & ~pop);
    end
  end
`endif

  logic ovr_reg;
  logic tx_tbr_reg, tx_start_reg;
  logic [7:0] tx_data_reg;
  logic tbr_int;

  // tx_start masks tbr so a write in the cycle right after an issue cannot issue again.
  assign tbr_int = tx_tbr_reg & ~tx_start_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_reg      <= 1'b0;
      tx_tbr_reg   <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      ovr_reg      <= ovr_event | (ovr_reg & ~stat_rd);
      tx_tbr_reg   <= tx_tbr;
      tx_start_reg <= data_wr & tbr_int;
      if (data_wr & tbr_int)
        tx_data_reg <= bus.databus_in;
    end
  end

  always_comb begin
    bus.databus_out = 8'h00;
    if (rd_access) begin
      case (bus.ioaddr)
        2'b00:   bus.databus_out = empty ? 8'h00 : head;
        2'b01:   bus.databus_out = {5'b00000, ovr_reg, tbr_int, ~empty};
        2'b10:   bus.databus_out = div_reg[7:0];
        default: bus.databus_out = div_reg[15:8];
      endcase
    end
  end

  assign bus.rda  = ~empty;
  assign bus.tbr  = tbr_int;
  assign baud     = baud_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: queue-based behavioural model compared every cycle, plus directed literal checks.
module tb_spart_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spart_bus_ctrl_if bus ();
  logic       baud, rx_rda, tx_tbr, tx_start;
  logic [7:0] rx_data, tx_data;

  spart_bus_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .baud     (baud),
    .rx_rda   (rx_rda),
    .rx_data  (rx_data),
    .tx_tbr   (tx_tbr),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

`ifdef SPART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges since reset release, used to time baud ticks.
  int edge_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // Behavioural model: rx buffer as a queue, baud as "edges until next tick".
  logic [7:0]  mq[$];
  bit          m_ovr, m_txtbr, m_txs, m_baud, m_prev;
  logic [7:0]  m_txd, m_stage, exp_db;
  logic [15:0] m_div;
  int          m_wait;
  bit          e_tbr, e_rda, rd, wr, push, popd, ovr_ev;
  logic [1:0]  a;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
      m_ovr = 0; m_txtbr = 0; m_txs = 0; m_baud = 0; m_prev = 1;
      m_txd = 8'h00; m_div = 16'd162; m_stage = 8'hA2; m_wait = 163;
    end else begin
      e_tbr = m_txtbr & ~m_txs;
      e_rda = (mq.size() != 0);
      rd = bus.iocs & bus.iorw;
      wr = bus.iocs & ~bus.iorw;
      a  = bus.ioaddr;
      exp_db = 8'h00;
      if (rd) begin
        case (a)
          2'd0: exp_db = e_rda ? mq[0] : 8'h00;
          2'd1: exp_db = {5'b0, m_ovr, e_tbr, e_rda};
          2'd2: exp_db = m_div[7:0];
          default: exp_db = m_div[15:8];
        endcase
      end
      chk("m_baud", 16'(baud), 16'(m_baud));
      chk("m_rda", 16'(bus.rda), 16'(e_rda));
      chk("m_tbr", 16'(bus.tbr), 16'(e_tbr));
      chk("m_tx_start", 16'(tx_start), 16'(m_txs));
      chk("m_tx_data", 16'(tx_data), 16'(m_txd));
      chk("m_databus", 16'(bus.databus_out), 16'(exp_db));
      // Advance the model across the coming clock edge.
      push   = rx_rda && !m_prev;
      popd   = rd && a == 2'd0 && mq.size() > 0;
      ovr_ev = push && mq.size() == CAP && !popd;
      if (popd) void'(mq.pop_front());
      if (push && !ovr_ev) mq.push_back(rx_data);
      if (ovr_ev) m_ovr = 1;
      else if (rd && a == 2'd1) m_ovr = 0;
      if (wr && a == 2'd0 && e_tbr) begin
        m_txd = bus.databus_in;
        m_txs = 1;
      end else begin
        m_txs = 0;
      end
      m_txtbr = tx_tbr;
      m_prev  = rx_rda;
      if (wr && a == 2'd3) begin
        m_div  = {bus.databus_in, m_stage};
        m_wait = int'(m_div) + 1;
        m_baud = 0;
      end else begin
        m_wait--;
        m_baud = (m_wait == 0);
        if (m_baud) m_wait = int'(m_div) + 1;
      end
      if (wr && a == 2'd2) m_stage = bus.databus_in;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] ad, input logic [7:0] d);
    bus.iocs = 1; bus.iorw = 0; bus.ioaddr = ad; bus.databus_in = d;
    @(posedge clk); #1;
    bus.iocs = 0;
  endtask

  task automatic bus_read(input logic [1:0] ad, output logic [7:0] d);
    bus.iocs = 1; bus.iorw = 1; bus.ioaddr = ad;
    @(negedge clk);
    d = bus.databus_out;
    @(posedge clk); #1;
    bus.iocs = 0; bus.iorw = 0;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    rx_rda = 0;
    tick(20);
    rx_data = d;
    rx_rda  = 1;
    tick(1);
  endtask

  task automatic wait_baud(input string name, output int k);
    bit found;
    found = 0;
    k = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (baud === 1'b1) begin
        found = 1;
        k = edge_cnt;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no baud tick, expected one within 400 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] d;
  int k1, k2, c;

  initial begin
    bus.iocs = 0; bus.iorw = 0; bus.ioaddr = 2'd0; bus.databus_in = 8'h00;
    rx_rda = 1; rx_data = 8'h00; tx_tbr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rda", 16'(bus.rda), 16'h0);
    chk("rst_tbr", 16'(bus.tbr), 16'h0);
    chk("rst_baud", 16'(baud), 16'h0);
    chk("rst_tx_start", 16'(tx_start), 16'h0);
    chk("rst_tx_data", 16'(tx_data), 16'h00);
    chk("rst_databus", 16'(bus.databus_out), 16'h00);
    @(posedge clk); #1;
    rst = 0;

    tx_tbr = 1;
    tick(2);
    bus_read(2'd1, d);
    chk("status_idle", 16'(d), 16'h02);
    wait_baud("baud_first", k1);
    chk("baud_first_edge", 16'(k1), 16'd163);
    wait_baud("baud_second", k2);
    chk("baud_period_reset", 16'(k2 - k1), 16'd163);

    bus_write(2'd2, 8'h09);
    bus_write(2'd3, 8'h00);
    c = edge_cnt;
    chk("baud_commit_quiet", 16'(baud), 16'h0);
    wait_baud("baud_after_commit", k1);
    chk("baud_commit_delay", 16'(k1 - c), 16'd10);
    wait_baud("baud_div9", k2);
    chk("baud_period_div9", 16'(k2 - k1), 16'd10);
    bus_read(2'd2, d);
    chk("div_lo_read", 16'(d), 16'h09);
    bus_read(2'd3, d);
    chk("div_hi_read", 16'(d), 16'h00);

    rx_byte(8'hA5);
    chk("rx_rda_set", 16'(bus.rda), 16'h1);
    bus_read(2'd0, d);
    chk("rx_data_read", 16'(d), 16'hA5);
    chk("rx_rda_clr", 16'(bus.rda), 16'h0);

    rx_byte(8'h11);
    rx_byte(8'h22);
    bus_read(2'd0, d);
    chk("two_first", 16'(d), 16'h11);
    bus_read(2'd1, d);
`ifdef SPART_RX_FIFO_EN
    chk("two_overrun", 16'(d[2]), 16'h0);
    bus_read(2'd0, d);
    chk("two_second", 16'(d), 16'h22);
`else
    chk("two_overrun", 16'(d[2]), 16'h1);
`endif

    bus.iocs = 1; bus.iorw = 0; bus.ioaddr = 2'd0; bus.databus_in = 8'h5A;
    @(posedge clk); #1;
    bus.databus_in = 8'h77;
    chk("tx_pulse", 16'(tx_start), 16'h1);
    chk("tx_data", 16'(tx_data), 16'h5A);
    @(posedge clk); #1;
    bus.iocs = 0;
    chk("tx_no_double", 16'(tx_start), 16'h0);
    chk("tx_data_hold", 16'(tx_data), 16'h5A);

    bus_write(2'd1, 8'hFF);
    for (int i = 0; i < CAP; i++) rx_byte(8'h30 + 8'(i));
    rx_rda = 0;
    tick(3);
    rx_data = 8'h44; rx_rda = 1;
    bus.iocs = 1; bus.iorw = 1; bus.ioaddr = 2'd0;
    @(negedge clk);
    chk("simul_pop_head", 16'(bus.databus_out), 16'h30);
    @(posedge clk); #1;
    bus.iocs = 0; bus.iorw = 0;
    chk("simul_rda", 16'(bus.rda), 16'h1);
    bus_read(2'd1, d);
    chk("simul_overrun", 16'(d[2]), 16'h0);
    for (int i = 1; i < CAP; i++) begin
      bus_read(2'd0, d);
      chk("simul_drain", 16'(d), 16'(8'h30 + 8'(i)));
    end
    bus_read(2'd0, d);
    chk("simul_new_byte", 16'(d), 16'h44);

    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h00);
    chk("div0_commit_quiet", 16'(baud), 16'h0);
    tick(1);
    chk("div0_tick1", 16'(baud), 16'h1);
    tick(1);
    chk("div0_tick2", 16'(baud), 16'h1);

    rx_byte(8'h66);
    chk("pre_rst_rda", 16'(bus.rda), 16'h1);
    rst = 1;
    #1;
    chk("mid_rst_rda", 16'(bus.rda), 16'h0);
    chk("mid_rst_tx_data", 16'(tx_data), 16'h00);
    chk("mid_rst_baud", 16'(baud), 16'h0);
    tick(2);
    rst = 0;
    bus_read(2'd0, d);
    chk("post_rst_data", 16'(d), 16'h00);
    bus_read(2'd2, d);
    chk("post_rst_div_lo", 16'(d), 16'hA2);
    bus_read(2'd3, d);
    chk("post_rst_div_hi", 16'(d), 16'h00);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
